// File: rtl/ooo_pkg.sv
// ooo_pkg: definitions shared by the out-of-order core's result path.
//   CDB_DATA_W  : width of a result value (64)
//   CDB_VAL_W   : width of a broadcast value, data plus ready flag (65)
//   CDB_RDY_BIT : position of the ready flag inside a broadcast value (64)
//   rob_tag_w() : ROB tag width for a given ROB depth
//   cdb_pkt_t   : broadcast packet {tag, val} for the default ROB depth
package ooo_pkg;

    localparam int CDB_DATA_W  = 64;
    localparam int CDB_VAL_W   = CDB_DATA_W + 1;
    localparam int CDB_RDY_BIT = 64;

    // Tags span 0..rob_size so one code beyond the ROB range is available.
    function automatic int rob_tag_w(input int rob_size);
        return $clog2(rob_size + 1);
    endfunction

    localparam int ROB_SIZE_DEF  = 16;
    localparam int ROB_TAG_W_DEF = rob_tag_w(ROB_SIZE_DEF);

    typedef struct packed {
        logic [ROB_TAG_W_DEF-1:0] tag;
        logic [CDB_VAL_W-1:0]     val;
    } cdb_pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   i_req   : request vector, one bit per requester
//   i_ptr   : highest-priority index this cycle (must be < N)
//   o_grant : one-hot grant, zero when no request is set
//   o_idx   : encoded index of the granted requester (0 when none)
//   o_any   : a grant exists
// The first set request at or after i_ptr wins, wrapping modulo N.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int i = 0; i < N; i++) begin
            // Candidate (ptr + i) mod N; one extra bit so the wrap compare
            // works for non-power-of-two N.
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(N))
                w_sum = w_sum - (IDX_W+1)'(N);
            w_cand = w_sum[IDX_W-1:0];
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the common data bus.
//   clk_i, reset_i : clock, synchronous active-low reset
//   flush_i        : drop all held results and the pending broadcast
//   req_valid_i    : unit k offers a result this cycle
//   req_tag_i      : ROB tag of each offer
//   req_val_i      : 64-bit data of each offer
//   req_stall_o    : unit k must hold its offer (slot full and not granted)
//   cdb_ready_i    : ROB can take a broadcast; low freezes slots and pointer
//   cdbValid_o     : registered broadcast valid
//   cdbTag_o       : broadcast tag
//   cdbVal_o       : broadcast value, bit 64 set on every broadcast
//   cdbSrc_o       : index of the producer that was granted
// Each unit owns a one-entry slot. One slot is granted per cycle and its
// contents are registered onto the bus; a granted slot may be refilled in
// the same cycle, so a unit granted every cycle streams at full rate.
module cdb_arbiter
    import ooo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ROBsize    = 16,
    parameter int ROBsizeLog = rob_tag_w(ROBsize)
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  flush_i,
    input  logic [NUM_REQ-1:0]                    req_valid_i,
    input  logic [NUM_REQ-1:0][ROBsizeLog-1:0]    req_tag_i,
    input  logic [NUM_REQ-1:0][CDB_DATA_W-1:0]    req_val_i,
    output logic [NUM_REQ-1:0]                    req_stall_o,
    input  logic                                  cdb_ready_i,
    output logic                                  cdbValid_o,
    output logic [ROBsizeLog-1:0]                 cdbTag_o,
    output logic [CDB_VAL_W-1:0]                  cdbVal_o,
    output logic [$clog2(NUM_REQ)-1:0]            cdbSrc_o
);

    localparam int SRC_W = $clog2(NUM_REQ);

    // Slot state
    logic [NUM_REQ-1:0]                 r_slot_valid;
    logic [NUM_REQ-1:0][ROBsizeLog-1:0] r_slot_tag;
    logic [NUM_REQ-1:0][CDB_DATA_W-1:0] r_slot_val;
    logic [SRC_W-1:0]                   r_rr_ptr;

    // Broadcast register
    logic                               r_cdb_valid;
    logic [ROBsizeLog-1:0]              r_cdb_tag;
    logic [CDB_VAL_W-1:0]               r_cdb_val;
    logic [SRC_W-1:0]                   r_cdb_src;

    logic [NUM_REQ-1:0]                 w_arb_req;
    logic [NUM_REQ-1:0]                 w_grant;
    logic [SRC_W-1:0]                   w_grant_idx;
    logic                               w_grant_any;
    logic [NUM_REQ-1:0]                 w_stall;
    logic [NUM_REQ-1:0]                 w_load;
    logic [CDB_VAL_W-1:0]               w_bcast_val;
    logic [SRC_W-1:0]                   w_ptr_next;

    // Backpressure and flush both suppress the grant, which is what freezes
    // the slots and the pointer.
    assign w_arb_req = r_slot_valid & {NUM_REQ{cdb_ready_i & ~flush_i}};

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (SRC_W)
    ) u_rr_arbiter (
        .i_req   (w_arb_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_any   (w_grant_any)
    );

    // Stall depends only on state and grant, never on req_valid_i. In the
    // flush cycle nothing is stalled: offers are dropped rather than held.
    assign w_stall     = flush_i ? '0 : (r_slot_valid & ~w_grant);
    assign w_load      = req_valid_i & ~w_stall;
    assign req_stall_o = w_stall;

    always_comb begin
        w_bcast_val = {1'b0, r_slot_val[w_grant_idx]};
        w_bcast_val[CDB_RDY_BIT] = 1'b1;
    end

    assign w_ptr_next = (w_grant_idx == SRC_W'(NUM_REQ-1)) ? '0
                                                           : w_grant_idx + 1'b1;

    // Slots: a load wins over the drain so drain+refill keeps the slot valid.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_slot_valid <= '0;
            r_slot_tag   <= '0;
            r_slot_val   <= '0;
        end else if (flush_i) begin
            r_slot_valid <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (w_load[k]) begin
                    r_slot_valid[k] <= 1'b1;
                    r_slot_tag[k]   <= req_tag_i[k];
                    r_slot_val[k]   <= req_val_i[k];
                end else if (w_grant[k]) begin
                    r_slot_valid[k] <= 1'b0;
                end
            end
        end
    end

    // Pointer moves past the winner; untouched by flush.
    always_ff @(posedge clk_i) begin
        if (!reset_i)
            r_rr_ptr <= '0;
        else if (w_grant_any)
            r_rr_ptr <= w_ptr_next;
    end

    // Broadcast: tag/value/source keep their last values when idle.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_val   <= '0;
            r_cdb_src   <= '0;
        end else if (w_grant_any) begin
            r_cdb_valid <= 1'b1;
            r_cdb_tag   <= r_slot_tag[w_grant_idx];
            r_cdb_val   <= w_bcast_val;
            r_cdb_src   <= w_grant_idx;
        end else begin
            r_cdb_valid <= 1'b0;
        end
    end

    assign cdbValid_o = r_cdb_valid;
    assign cdbTag_o   = r_cdb_tag;
    assign cdbVal_o   = r_cdb_val;
    assign cdbSrc_o   = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for cdb_arbiter (NUM_REQ=4, ROBsize=16).
// Offers that are expected to reach the bus are queued when accepted; a
// monitor pops one entry per broadcast and compares tag, value and source.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 5;

    typedef struct {
        logic [TW-1:0] tag;
        logic [64:0]   val;
        logic [1:0]    src;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                flush = 1'b0;
    logic                rdy = 1'b1;
    logic [N-1:0]        rv = '0;
    logic [N-1:0][TW-1:0] rtag = '0;
    logic [N-1:0][63:0]  rval = '0;
    logic [N-1:0]        stall;
    logic                cdbValid_o;
    logic [TW-1:0]       cdbTag_o;
    logic [64:0]         cdbVal_o;
    logic [1:0]          cdbSrc_o;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    logic [N-1:0] st_smp;
    logic         obs_vld;
    logic [TW-1:0] obs_tag;
    logic [64:0]  obs_val;
    logic [1:0]   obs_src;
    logic [3:0]   m, mi;

    cdb_arbiter #(.NUM_REQ(N), .ROBsize(16)) dut (
        .clk_i       (clk),
        .reset_i     (rst_n),
        .flush_i     (flush),
        .req_valid_i (rv),
        .req_tag_i   (rtag),
        .req_val_i   (rval),
        .req_stall_o (stall),
        .cdb_ready_i (rdy),
        .cdbValid_o  (cdbValid_o),
        .cdbTag_o    (cdbTag_o),
        .cdbVal_o    (cdbVal_o),
        .cdbSrc_o    (cdbSrc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bus cycle: present offers, sample mid-cycle, queue accepted offers
    // selected by push, then advance the data of every accepted unit.
    task automatic cyc(input logic [N-1:0] offer, input logic [N-1:0] push);
        logic [N-1:0] acc;
        rv = offer;
        @(negedge clk);
        st_smp  = stall;
        obs_vld = cdbValid_o;
        obs_tag = cdbTag_o;
        obs_val = cdbVal_o;
        obs_src = cdbSrc_o;
        acc = '0;
        if (rst_n && !flush) begin
            for (int k = 0; k < N; k++) begin
                if (offer[k] && !stall[k]) begin
                    acc[k] = 1'b1;
                    if (push[k])
                        exp_q.push_back('{tag: rtag[k], val: {1'b1, rval[k]}, src: 2'(k)});
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
                rtag[k] = rtag[k] + 5'd8;
                rval[k] = {$urandom, $urandom};
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc('0, '0);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && cdbValid_o) begin
            if (exp_q.size() == 0) begin
                chk("bcast_unexpected", 72'(exp_q.size()), 72'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("cdb_tag", 72'(cdbTag_o), 72'(e.tag));
                chk("cdb_val", 72'(cdbVal_o), 72'(e.val));
                chk("cdb_src", 72'(cdbSrc_o), 72'(e.src));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        cyc('0, '0);
        cyc('0, '0);
        chk("rst_vld",   72'(obs_vld), 72'd0);
        chk("rst_tag",   72'(obs_tag), 72'd0);
        chk("rst_val",   72'(obs_val), 72'd0);
        chk("rst_src",   72'(obs_src), 72'd0);
        chk("rst_stall", 72'(st_smp),  72'd0);
        rst_n = 1'b1;

        // Single offer: unit 2, tag 5, value 0xAB; on the bus two edges later
        rtag[2] = 5'd5;
        rval[2] = 64'hAB;
        cyc(4'b0100, 4'b0100);
        chk("t1_stall", 72'(st_smp), 72'd0);
        cyc('0, '0);
        chk("t1_lat1", 72'(obs_vld), 72'd0);
        cyc('0, '0);
        chk("t1_lat2", 72'(obs_vld), 72'd1);
        chk("t1_val",  72'(obs_val), 72'h1_0000_0000_0000_00AB);
        cyc('0, '0);
        cyc('0, '0);
        chk("t1_drain", 72'(exp_q.size()), 72'd0);

        // All units offering every cycle: grant order 0,1,2,3,...
        do_reset();
        for (int k = 0; k < N; k++) begin
            rtag[k] = 5'(k);
            rval[k] = {$urandom, $urandom};
        end
        for (int i = 0; i < 12; i++) begin
            cyc(4'b1111, 4'b1111);
            if (i >= 1) begin
                m  = 4'b0001 << ((i - 1) % 4);
                mi = ~m;
                chk("t2_stallmask", 72'(st_smp), 72'(mi));
            end
            if (i >= 2)
                chk("t2_bcast", 72'(obs_vld), 72'd1);
        end
        for (int i = 0; i < 6; i++) cyc('0, '0);
        chk("t2_drain", 72'(exp_q.size()), 72'd0);

        // Backpressure freeze with slots 1 and 3 full
        do_reset();
        rtag[1] = 5'd9;
        rtag[3] = 5'd20;
        cyc(4'b1010, 4'b1010);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc('0, '0);
            chk("t3_frz_stall", 72'(st_smp),  72'b1010);
            chk("t3_frz_vld",   72'(obs_vld), 72'd0);
        end
        rdy = 1'b1;
        cyc('0, '0);
        chk("t3_rel_stall", 72'(st_smp),  72'b1000);
        chk("t3_rel_vld",   72'(obs_vld), 72'd0);
        cyc('0, '0);
        chk("t3_first_src", 72'(obs_src), 72'd1);
        cyc('0, '0);
        chk("t3_second_src", 72'(obs_src), 72'd3);
        cyc('0, '0);
        chk("t3_drain", 72'(exp_q.size()), 72'd0);

        // Same-cycle drain and refill on unit 0
        do_reset();
        rtag[0] = 5'd3;
        cyc(4'b0001, 4'b0001);
        rtag[0] = 5'd7;
        cyc(4'b0001, 4'b0001);
        chk("t4_nostall", 72'(st_smp[0]), 72'd0);
        cyc('0, '0);
        chk("t4_tag3", 72'(obs_tag), 72'd3);
        cyc('0, '0);
        chk("t4_vld7", 72'(obs_vld), 72'd1);
        chk("t4_tag7", 72'(obs_tag), 72'd7);
        cyc('0, '0);
        chk("t4_drain", 72'(exp_q.size()), 72'd0);

        // Flush with slots 0 and 2 full and a broadcast on the bus
        do_reset();
        rtag[0] = 5'd1;
        rtag[1] = 5'd17;
        rtag[2] = 5'd2;
        cyc(4'b0101, 4'b0001);
        cyc(4'b0001, 4'b0000);
        chk("t5_pre_stall", 72'(st_smp), 72'b0100);
        flush = 1'b1;
        cyc(4'b0010, 4'b0000);
        chk("t5_flush_stall", 72'(st_smp),  72'd0);
        chk("t5_flush_vld",   72'(obs_vld), 72'd1);
        flush = 1'b0;
        cyc('0, '0);
        chk("t5_post_vld",   72'(obs_vld), 72'd0);
        chk("t5_post_stall", 72'(st_smp),  72'd0);
        for (int i = 0; i < 4; i++) cyc('0, '0);
        chk("t5_drain", 72'(exp_q.size()), 72'd0);

        // Reset while slots are full, then a lone offer from unit 3
        do_reset();
        for (int k = 0; k < N; k++) rtag[k] = 5'(10 + k);
        cyc(4'b1111, 4'b0001);
        cyc('0, '0);
        cyc('0, '0);
        rst_n = 1'b0;
        cyc('0, '0);
        rst_n = 1'b1;
        rtag[3] = 5'd30;
        cyc(4'b1000, 4'b1000);
        chk("t6_vld",   72'(obs_vld), 72'd0);
        chk("t6_tag",   72'(obs_tag), 72'd0);
        chk("t6_val",   72'(obs_val), 72'd0);
        chk("t6_src",   72'(obs_src), 72'd0);
        chk("t6_stall", 72'(st_smp),  72'd0);
        cyc('0, '0);
        chk("t6_lat1", 72'(obs_vld), 72'd0);
        cyc('0, '0);
        chk("t6_lat2", 72'(obs_vld), 72'd1);
        chk("t6_src3", 72'(obs_src), 72'd3);
        cyc('0, '0);
        chk("t6_drain", 72'(exp_q.size()), 72'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter for the common data bus (CDB) that carries completed results back to the ROB and to every reservation station's commit-forwarding inputs (tag plus 65-bit value, bit 64 = ready). Each functional unit's result output has a one-entry holding slot. The arbiter picks at most one slot per cycle and drives a registered broadcast. It sits between the execute/memory units and the ROB/reservation-station broadcast inputs.

## Interface
Parameters:
- NUM_REQ, 4, number of result producers (functional units); minimum 2.
- ROBsize, 16, ROB entries.
- ROBsizeLog, $clog2(ROBsize+1), tag width.

Ports:
- clk_i  in  1  clock; single clock domain.
- reset_i  in  1  synchronous, active-low reset.
- flush_i  in  1  discard all held results and the CDB output (mispredict recovery).
- req_valid_i  in  NUM_REQ  unit k presents a result this cycle.
- req_tag_i  in  NUM_REQ x ROBsizeLog  ROB tag of the result.
- req_val_i  in  NUM_REQ x 64  result data.
- req_stall_o  out  NUM_REQ  unit k must hold its result; the offer is not accepted.
- cdb_ready_i  in  1  ROB can accept a broadcast this cycle.
- cdbValid_o  out  1  broadcast valid.
- cdbTag_o  out  ROBsizeLog  broadcast tag.
- cdbVal_o  out  65  broadcast value; bit 64 is always 1 when cdbValid_o is high.
- cdbSrc_o  out  $clog2(NUM_REQ)  index of the granted producer (debug and performance counters).

## Operation
- Per-requester state: slot_valid[k], slot_tag[k], slot_val[k].
- Grant, combinational:
  - Among slots with slot_valid set, choose the first at or after rr_ptr, wrapping modulo NUM_REQ.
  - grant is one-hot and is all zero if cdb_ready_i=0, flush_i=1, or no slot is valid.
- Accept:
  - req_stall_o[k] = slot_valid[k] & ~grant[k].
  - If req_valid_i[k] & ~req_stall_o[k], slot k loads the tag and value at the edge. A slot drained and refilled in the same cycle stays valid with the new data.
  - When req_stall_o[k]=1, unit k holds its tag and value stable. The arbiter ignores those inputs.
- Broadcast register:
  - If a grant exists: cdbValid_o<=1, cdbTag_o<=slot_tag[g], cdbVal_o<={1'b1,slot_val[g]}, cdbSrc_o<=g.
  - Otherwise cdbValid_o<=0. Tag, value and source hold their last values.
- Pointer: on a grant to g, rr_ptr<=(g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Flush, highest priority below reset:
  - At the edge: all slot_valid<=0 and cdbValid_o<=0; rr_ptr is kept.
  - Offers made in the flush cycle are dropped, and req_stall_o is 0 that cycle.
- Reset (reset_i=0 at an edge):
  - slots invalid, rr_ptr=0, cdbValid_o=0, cdbTag_o=0, cdbVal_o=0, cdbSrc_o=0.
  - req_stall_o reads 0 after reset because it is derived from slot state.
  - Reset asserted mid-operation discards all held results with no broadcast.

## Timing
- Minimum latency is 2 edges. An offer in cycle t is in its slot after edge t+1, is granted in cycle t+1, and is on the CDB in cycle t+2.
- Throughput is one broadcast per cycle. Each unit can sustain one result per cycle while it is granted every cycle.
- Fairness: with all NUM_REQ slots continuously valid and cdb_ready_i=1, each slot is granted exactly once every NUM_REQ cycles.
- Worst-case wait for a held slot is NUM_REQ-1 grant cycles.
- cdb_ready_i=0 freezes all slots and rr_ptr. The next cycle shows cdbValid_o=0. The held broadcast is not repeated.
- req_stall_o is purely combinational from state, grant and cdb_ready_i. It has no path from req_valid_i.

## Structure
- Shared package (ooo_pkg): the CDB packet typedef {tag, 65-bit val}, the ready-bit index constant 64, and the ROB tag width function.
- One natural sub-module: rr_arbiter. It takes the NUM_REQ request vector and rr_ptr and produces a one-hot grant plus its encoded index. It is reusable for issue-port arbitration.
- The top level holds the slot registers, the pointer, and the output register.

## Test plan
- Reset then single offer: unit 2 offers tag 5, val 0xAB at cycle 1. Expect cdbValid_o=1, cdbTag_o=5, cdbVal_o=0x1_0000_0000_0000_00AB, cdbSrc_o=2 at cycle 3, and no stall.
- All 4 units offer every cycle for 12 cycles. Expect cdbSrc_o to cycle 0,1,2,3,… with one broadcast per cycle, and every unit stalled 3 of every 4 cycles.
- cdb_ready_i=0 for 3 cycles with slots 1 and 3 full. Expect no broadcast and stall_o[1]=stall_o[3]=1. After release, expect slot 1 then slot 3, with rr_ptr unchanged across the freeze.
- Same-cycle drain and refill: unit 0 is granted while offering tag 7. Expect no stall, and tag 7 broadcast two cycles later.
- flush_i with slots 0 and 2 full and cdbValid_o=1. Expect cdbValid_o=0 next cycle, no later broadcast of those tags, and the flush-cycle offer from unit 1 dropped.
- reset_i low while all slots are full. Expect all outputs 0 after the edge. A subsequent offer from unit 3 is broadcast first with cdbSrc_o=3 (rr_ptr=0, only request).
